ram_loader: RTL and testbench



---
 rtl/ram_loader.sv | 170 +++++++++++++++++
 tb/tb_ram_loader.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_loader.sv
// ram_loader: boot-time loader that streams a length-prefixed image into RAM and holds the CPU until it is complete.
// Latency: each payload byte is written one cycle after acceptance (registered write port); throughput is one byte per clock.
// Backpressure: in_ready is high only while the loader still expects header, payload or checksum bytes; low in DONE/ERROR.
// Optional trailing XOR checksum byte is enabled by defining RAM_LOADER_CHECKSUM_EN.

module ram_loader #(
  parameter logic [14:0] BASE_ADDR = 15'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [14:0] ram_addr,
  output logic [7:0]  ram_wdata,
  output logic        ram_we,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_err
);

  typedef enum logic [2:0] {
    ST_LEN_HI = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_DATA   = 3'd2,
`ifdef RAM_LOADER_CHECKSUM_EN
    ST_CSUM   = 3'd3,
`endif
    ST_DONE   = 3'd4,
    ST_ERROR  = 3'd5
  } state_t;

  // State after the last payload byte (or after an empty header).
`ifdef RAM_LOADER_CHECKSUM_EN
  localparam state_t ST_TAIL = ST_CSUM;
`else
  localparam state_t ST_TAIL = ST_DONE;
`endif

  state_t      state_q, state_d;
  logic [14:0] len_q, len_d;
  logic [14:0] idx_q, idx_d;
  logic [7:0]  xor_q, xor_d;
  logic        in_ready_q, in_ready_d;
  logic [14:0] ram_addr_q, ram_addr_d;
  logic [7:0]  ram_wdata_q, ram_wdata_d;
  logic        ram_we_q, ram_we_d;
  logic        cpu_hold_q, cpu_hold_d;
  logic        load_done_q, load_done_d;
  logic        load_err_q, load_err_d;

  logic        accept;
  logic [14:0] len_full;
  logic [14:0] idx_inc;

  assign accept   = in_valid && in_ready_q;
  assign len_full = {len_q[14:8], in_data};
  assign idx_inc  = idx_q + 15'd1;

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    idx_d       = idx_q;
    xor_d       = xor_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ram_we_d    = 1'b0;

    case (state_q)
      ST_LEN_HI: begin
        if (accept) begin
          // Bit 7 of the high length byte is reserved and dropped.
          len_d   = {in_data[6:0], len_q[7:0]};
          xor_d   = 8'h00;
          state_d = ST_LEN_LO;
        end
      end
      ST_LEN_LO: begin
        if (accept) begin
          len_d = len_full;
          if (len_full == 15'd0) begin
            state_d = ST_TAIL;
          end else begin
            idx_d   = 15'd0;
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (accept) begin
          // 15-bit add wraps the address bus from 7FFF back to 0000.
          ram_we_d    = 1'b1;
          ram_addr_d  = BASE_ADDR + idx_q;
          ram_wdata_d = in_data;
          xor_d       = xor_q ^ in_data;
          idx_d       = idx_inc;
          if (idx_inc == len_q) begin
            state_d = ST_TAIL;
          end
        end
      end
`ifdef RAM_LOADER_CHECKSUM_EN
      ST_CSUM: begin
        if (accept) begin
          state_d = (in_data == xor_q) ? ST_DONE : ST_ERROR;
        end
      end
`endif
      ST_DONE:  state_d = ST_DONE;
      ST_ERROR: state_d = ST_ERROR;
      default:  state_d = ST_ERROR;
    endcase

    in_ready_d = (state_d == ST_LEN_HI) || (state_d == ST_LEN_LO) ||
`ifdef RAM_LOADER_CHECKSUM_EN
                 (state_d == ST_CSUM) ||
`endif
                 (state_d == ST_DATA);

`ifdef RAM_LOADER_CHECKSUM_EN
    // Status flips on the edge that accepts the checksum byte.
    load_done_d = (state_d == ST_DONE);
    load_err_d  = (state_d == ST_ERROR);
`else
    // Release one cycle after entering DONE so the last write lands while the CPU is held.
    load_done_d = (state_q == ST_DONE);
    load_err_d  = 1'b0;
`endif
    cpu_hold_d = !load_done_d;
  end

  // State and output registers; reset aborts any in-flight write immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_LEN_HI;
      len_q       <= 15'd0;
      idx_q       <= 15'd0;
      xor_q       <= 8'h00;
      in_ready_q  <= 1'b0;
      ram_addr_q  <= 15'd0;
      ram_wdata_q <= 8'h00;
      ram_we_q    <= 1'b0;
      cpu_hold_q  <= 1'b1;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      xor_q       <= xor_d;
      in_ready_q  <= in_ready_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      ram_we_q    <= ram_we_d;
      cpu_hold_q  <= cpu_hold_d;
      load_done_q <= load_done_d;
      load_err_q  <= load_err_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign ram_we    = ram_we_q;
  assign cpu_hold  = cpu_hold_q;
  assign load_done = load_done_q;
  assign load_err  = load_err_q;

endmodule

// File: tb/tb_ram_loader.sv
// Bench for ram_loader: directed sequence of loads with randomized payloads and handshake gaps.
// Expected RAM writes come from a simple model: byte i of the payload lands at (BASE + i) mod 2^15.
// Follows RAM_LOADER_CHECKSUM_EN the same way as the design.

module tb_ram_loader;

  localparam logic [14:0] BASE = 15'h7FFE;

  logic        clk;
  logic        rst_n;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [14:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic        ram_we;
  logic        cpu_hold;
  logic        load_done;
  logic        load_err;

  int tests = 0;
  int fails = 0;

  logic [7:0]  pay[$];
  logic [22:0] wr_log[$];
  bit          hdr7;
`ifdef RAM_LOADER_CHECKSUM_EN
  bit          bad_csum;
`endif

  ram_loader #(.BASE_ADDR(BASE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_we    (ram_we),
    .cpu_hold  (cpu_hold),
    .load_done (load_done),
    .load_err  (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every RAM write as seen by the RAM on the clock edge.
  always @(posedge clk) begin
    if (rst_n === 1'b1 && ram_we === 1'b1) wr_log.push_back({ram_addr, ram_wdata});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_wdata", ram_wdata, 0);
    check("rst_cpu_hold", cpu_hold, 1);
    check("rst_load_done", load_done, 0);
    check("rst_load_err", load_err, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rdy_before_edge", in_ready, 0);
    @(posedge clk);
    #1;
    check("rdy_after_edge", in_ready, 1);
    check("hold_after_rst", cpu_hold, 1);
  endtask

  // Offer one byte; gap_mode 0 = no idle, 1 = one idle cycle, 2 = random 0..3 idle cycles.
  task automatic send_byte(input logic [7:0] b, input int gap_mode);
    int gap;
    int n;
    bit acc;
    gap = (gap_mode == 0) ? 0 : (gap_mode == 1) ? 1 : int'($urandom_range(0, 3));
    repeat (gap) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    n   = 0;
    acc = 1'b0;
    while (!acc && n < 40) begin
      acc = in_ready;
      @(posedge clk);
      n++;
      if (!acc) @(negedge clk);
    end
    check("accept_timeout", acc, 1);
    #1;
  endtask

  task automatic load_image(input int gap_mode);
    logic [14:0] l;
    logic [14:0] a;
    logic [7:0]  x;
    l = 15'(pay.size());
    x = 8'h00;
    wr_log.delete();
    send_byte({hdr7, l[14:8]}, gap_mode);
    send_byte(l[7:0], gap_mode);
    foreach (pay[i]) begin
      send_byte(pay[i], gap_mode);
      a = BASE + i[14:0];
      check("wr_we", ram_we, 1);
      check("wr_addr", ram_addr, a);
      check("wr_data", ram_wdata, pay[i]);
      check("wr_hold", cpu_hold, 1);
      x = x ^ pay[i];
    end
`ifdef RAM_LOADER_CHECKSUM_EN
    check("csum_rdy", in_ready, 1);
    check("csum_done_pre", load_done, 0);
    send_byte(bad_csum ? (x ^ 8'h01) : x, gap_mode);
    check("csum_we", ram_we, 0);
    check("csum_rdy_after", in_ready, 0);
    check("csum_err", load_err, bad_csum);
    check("csum_done", load_done, !bad_csum);
    check("csum_hold", cpu_hold, bad_csum);
`else
    check("done_pre", load_done, 0);
    check("hold_pre", cpu_hold, 1);
    check("rdy_tail", in_ready, 0);
    @(posedge clk);
    #1;
    check("done_post", load_done, 1);
    check("hold_post", cpu_hold, 0);
    check("we_post", ram_we, 0);
    check("err_post", load_err, 0);
`endif
    @(negedge clk);
    in_valid = 1'b0;
    check("wr_count", wr_log.size(), pay.size());
    foreach (pay[i]) begin
      a = BASE + i[14:0];
      if (i < wr_log.size()) check("wr_log", wr_log[i], {a, pay[i]});
    end
  endtask

  task automatic offer_after_done();
    int n0;
    n0 = wr_log.size();
    repeat (4) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'($urandom_range(0, 255));
      #1;
      check("done_rdy", in_ready, 0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("done_nowr", wr_log.size(), n0);
    check("done_sticky", load_done, 1);
    check("done_hold", cpu_hold, 0);
  endtask

  task automatic rand_payload(input int len);
    pay.delete();
    for (int i = 0; i < len; i++) pay.push_back(8'($urandom_range(0, 255)));
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    hdr7     = 1'b0;
`ifdef RAM_LOADER_CHECKSUM_EN
    bad_csum = 1'b0;
`endif
    #3;

    // Back-to-back stream crossing the 7FFF -> 0000 wrap.
    do_reset();
    pay = '{8'hAA, 8'hBB, 8'hCC};
    load_image(0);
    offer_after_done();

    // in_valid toggling every other cycle.
    do_reset();
    rand_payload(5);
    hdr7 = 1'b1;
    load_image(1);
    offer_after_done();

    // Empty image with reserved header bit set.
    do_reset();
    pay.delete();
    hdr7 = 1'b1;
    load_image(2);

`ifdef RAM_LOADER_CHECKSUM_EN
    // Good then bad checksum on the same payload.
    do_reset();
    pay = '{8'h12, 8'h34};
    hdr7 = 1'b0;
    load_image(0);
    do_reset();
    bad_csum = 1'b1;
    load_image(0);
    bad_csum = 1'b0;
`endif

    // Reset after 2 of 4 payload bytes, then a full reload.
    do_reset();
    rand_payload(4);
    hdr7 = 1'b0;
    send_byte(8'h00, 0);
    send_byte(8'h04, 0);
    send_byte(pay[0], 0);
    send_byte(pay[1], 0);
    check("mid_we_before", ram_we, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_we_async", ram_we, 0);
    check("mid_hold_async", cpu_hold, 1);
    check("mid_rdy_async", in_ready, 0);
    in_valid = 1'b0;
    do_reset();
    rand_payload(8);
    load_image(2);

    // Random loads with random handshake gaps.
    for (int k = 0; k < 3; k++) begin
      do_reset();
      rand_payload(int'($urandom_range(1, 40)));
      hdr7 = 1'($urandom_range(0, 1));
      load_image(2);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
